// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline blocks.
// Holds the opcode encodings, the architectural NOP encoding, the default
// reset PC, and a helper that forces an address onto a word boundary.
package mips_pkg;

  typedef enum logic [5:0] {
    R_FORMAT = 6'h00,
    J        = 6'h02,
    BEQ      = 6'h04,
    LW       = 6'h23,
    SW       = 6'h2B
  } opcode_t;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;
  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority at each rising edge: hold > squash > memory wait (bubble) > load.
// A squash or a bubble loads the NOP encoding with valid cleared but still
// records the PC+4 of the slot.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ifid_hold       keep all fields unchanged
//   squash          flush / taken branch / taken jump
//   imem_ready      fetched word is valid this cycle
//   fetch_instr     word from instruction memory
//   fetch_pc4       PC+4 of the slot being fetched
//   ifid_instr/ifid_pc4/ifid_valid  register contents
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = MIPS_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifid_hold,
  input  logic        squash,
  input  logic        imem_ready,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (!ifid_hold) begin
      // flush wins over the hold only in the ID control mux, not here
      ifid_pc4 <= fetch_pc4;
      if (squash || !imem_ready) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= fetch_instr;
        ifid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IF/ID register and optional
// performance counters.
// Next-PC priority: pc_hold > branch > jump > memory wait > sequential.
// Jump targets take their upper nibble from the IF/ID copy of PC+4, since
// the jump is decoded in ID.
// Optional build macro FETCH_PERF_CNT_EN enables the fetch/stall/flush
// counters; without it the perf ports are tied to zero.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   pc_hold, ifid_hold, if_flush       hazard unit controls
//   branch_taken, branch_target        ID-resolved beq redirect
//   jump_taken, jump_index             ID-decoded j redirect
//   imem_addr, imem_req                fetch request (addr == PC)
//   imem_rdata, imem_ready             fetch response
//   pc_out                             current PC
//   ifid_instr, ifid_pc4, ifid_valid   IF/ID register to ID
//   perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt  counters
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_hold,
  input  logic        ifid_hold,
  input  logic        if_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic        squash;

  assign pc4       = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign imem_req  = ~reset;
  assign squash    = if_flush | branch_taken | jump_taken;

  always_comb begin
    pc_next = pc4;
    if (pc_hold)
      pc_next = pc_q;
    else if (branch_taken)
      pc_next = word_align(branch_target);
    else if (jump_taken)
      pc_next = {ifid_pc4[31:28], jump_index, 2'b00};
    else if (!imem_ready)
      pc_next = pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_next;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (reset),
    .ifid_hold   (ifid_hold),
    .squash      (squash),
    .imem_ready  (imem_ready),
    .fetch_instr (imem_rdata),
    .fetch_pc4   (pc4),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic load_valid;
  logic load_flush;

  // mirrors the IF/ID priority so the counters agree with what was loaded
  assign load_valid = ~ifid_hold & ~squash & imem_ready;
  assign load_flush = ~ifid_hold & squash;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (load_valid) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (pc_hold)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (load_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

  // ID gates redirects with the stall; a redirect under pc_hold would be lost
  a_no_redirect_on_hold : assert property (
    @(posedge clk) disable iff (reset) pc_hold |-> !(branch_taken || jump_taken)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        pc_hold;
  logic        ifid_hold;
  logic        if_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int n_total = 0;
  int n_pass  = 0;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc_hold        (pc_hold),
    .ifid_hold      (ifid_hold),
    .if_flush       (if_flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_taken     (jump_taken),
    .jump_index     (jump_index),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .pc_out         (pc_out),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .ifid_valid     (ifid_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: three fixed words, then a recognisable pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h8C01_0000;
      32'h4: return 32'h0022_1820;
      32'h8: return 32'h1000_0002;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] e_instr,
                          input logic [31:0] e_pc4, input logic e_valid);
    n_total++;
    if (ifid_instr !== e_instr) $display("FAIL %s.instr: got %h expected %h", name, ifid_instr, e_instr);
    else n_pass++;
    n_total++;
    if (ifid_pc4 !== e_pc4) $display("FAIL %s.pc4: got %h expected %h", name, ifid_pc4, e_pc4);
    else n_pass++;
    n_total++;
    if (ifid_valid !== e_valid) $display("FAIL %s.valid: got %b expected %b", name, ifid_valid, e_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_hold = 0; ifid_hold = 0; if_flush = 0;
    branch_taken = 0; branch_target = 0; jump_taken = 0; jump_index = 0;
    imem_ready = 1'b1;
    tick(); tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'h0);
    chk_ifid("rst_ifid", 32'h0, 32'h0, 1'b0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
    chk("rst_perf_flush", perf_flush_cnt, 32'h0);
    reset = 1'b0;
    #1;
    chk("req_after_rst", {31'd0, imem_req}, 32'h1);
    chk("addr_after_rst", imem_addr, 32'h0);
  endtask

  task automatic test_sequential();
    tick();
    chk("seq0_pc", pc_out, 32'h4);
    chk_ifid("seq0", 32'h8C01_0000, 32'h4, 1'b1);
    tick();
    chk("seq1_pc", pc_out, 32'h8);
    chk_ifid("seq1", 32'h0022_1820, 32'h8, 1'b1);
  endtask

  task automatic test_stall();
    pc_hold = 1; ifid_hold = 1; if_flush = 1;
    tick();
    chk("stall0_pc", pc_out, 32'h8);
    chk_ifid("stall0", 32'h0022_1820, 32'h8, 1'b1);
    tick();
    chk("stall1_pc", pc_out, 32'h8);
    chk_ifid("stall1", 32'h0022_1820, 32'h8, 1'b1);
    chk("stall_cnt", perf_stall_cnt, PERF ? 32'd2 : 32'd0);
    pc_hold = 0; ifid_hold = 0; if_flush = 0;
    tick();
    chk("stall_rel_pc", pc_out, 32'hC);
    chk_ifid("stall_rel", 32'h1000_0002, 32'hC, 1'b1);
    tick();
    chk("seq3_pc", pc_out, 32'h10);
    chk_ifid("seq3", 32'hA5A5_000C, 32'h10, 1'b1);
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_target = 32'h0000_0043;
    tick();
    branch_taken = 0;
    chk("br_pc", pc_out, 32'h40);
    chk_ifid("br_squash", 32'h0, 32'h14, 1'b0);
    tick();
    chk("br_next_pc", pc_out, 32'h44);
    chk_ifid("br_target_word", 32'hA5A5_0040, 32'h44, 1'b1);
  endtask

  task automatic test_jump();
    branch_taken = 1; branch_target = 32'h0040_000C;
    tick();
    branch_taken = 0;
    chk("jsetup_pc", pc_out, 32'h0040_000C);
    tick();
    chk("jsetup2_pc", pc_out, 32'h0040_0010);
    chk_ifid("jsetup", 32'hA5A5_000C, 32'h0040_0010, 1'b1);
    jump_taken = 1; jump_index = 26'h0000100;
    tick();
    jump_taken = 0;
    chk("jump_pc", pc_out, 32'h0000_0400);
    chk_ifid("jump_squash", 32'h0, 32'h0040_0014, 1'b0);
    tick();
    chk("jump_next_pc", pc_out, 32'h404);
    chk_ifid("jump_word", 32'hA5A5_0400, 32'h404, 1'b1);
  endtask

  task automatic test_branch_over_jump();
    branch_taken = 1; branch_target = 32'h20;
    jump_taken = 1; jump_index = 26'h3FF_FFFF;
    tick();
    branch_taken = 0; jump_taken = 0;
    chk("prio_pc", pc_out, 32'h20);
    chk_ifid("prio", 32'h0, 32'h408, 1'b0);
  endtask

  task automatic test_wait();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_pc", pc_out, 32'h20);
      chk_ifid("wait_bubble", 32'h0, 32'h24, 1'b0);
    end
    imem_ready = 1;
    tick();
    chk("wait_rel_pc", pc_out, 32'h24);
    chk_ifid("wait_rel", 32'hA5A5_0020, 32'h24, 1'b1);
  endtask

  task automatic test_mixed_hold();
    ifid_hold = 1;
    tick();
    ifid_hold = 0;
    chk("ifidhold_pc", pc_out, 32'h28);
    chk_ifid("ifidhold", 32'hA5A5_0020, 32'h24, 1'b1);
    pc_hold = 1;
    tick();
    pc_hold = 0;
    chk("pchold_pc", pc_out, 32'h28);
    chk_ifid("pchold", 32'hA5A5_0028, 32'h2C, 1'b1);
    tick();
    chk("pchold_rel_pc", pc_out, 32'h2C);
    chk_ifid("pchold_rel", 32'hA5A5_0028, 32'h2C, 1'b1);
    tick();
    chk("adv_pc", pc_out, 32'h30);
    chk_ifid("adv", 32'hA5A5_002C, 32'h30, 1'b1);
    chk("perf_fetch", perf_fetch_cnt, PERF ? 32'd11 : 32'd0);
    chk("perf_stall", perf_stall_cnt, PERF ? 32'd3 : 32'd0);
    chk("perf_flush", perf_flush_cnt, PERF ? 32'd4 : 32'd0);
  endtask

  task automatic test_reset_midwait();
    imem_ready = 0;
    tick();
    chk("mw_pc", pc_out, 32'h30);
    #2 reset = 1;
    #1;
    chk("mw_rst_pc", pc_out, 32'h0);
    chk("mw_rst_valid", {31'd0, ifid_valid}, 32'h0);
    chk("mw_rst_req", {31'd0, imem_req}, 32'h0);
    chk("mw_rst_perf", perf_fetch_cnt | perf_stall_cnt | perf_flush_cnt, 32'h0);
    tick();
    reset = 0; imem_ready = 1;
    #1;
    chk("mw_first_addr", imem_addr, 32'h0);
    tick();
    chk("mw_after_pc", pc_out, 32'h4);
    chk_ifid("mw_after", 32'h8C01_0000, 32'h4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_branch_over_jump();
    test_wait();
    test_mixed_hold();
    test_reset_midwait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC register, next-PC selection and the IF/ID pipeline register.
- Sits directly downstream of the hazard detection unit. Consumes its pc_hold, ifid_hold and if_flush outputs, plus branch/jump redirects resolved in ID.
- Feeds the ID stage with instruction, PC+4 and a valid bit.
- Tolerates an instruction memory with wait states via a ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on flush or bubble (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_hold  input  1  hazard unit: freeze PC this cycle.
- ifid_hold  input  1  hazard unit: freeze IF/ID register this cycle.
- if_flush  input  1  hazard unit / branch logic: squash the instruction being fetched.
- branch_taken  input  1  ID-resolved beq taken.
- branch_target  input  32  beq target; bits [1:0] ignored.
- jump_taken  input  1  ID-decoded j.
- jump_index  input  26  j instruction index field.
- imem_addr  output  32  fetch address, equal to the PC register (combinational).
- imem_req  output  1  fetch request; 1 whenever reset is low.
- imem_rdata  input  32  instruction word.
- imem_ready  input  1  imem_rdata is valid this cycle.
- pc_out  output  32  current PC.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc4  output  32  IF/ID PC+4.
- ifid_valid  output  1  IF/ID holds a real instruction.
- perf_fetch_cnt  output  32  retired fetches (see Optional Feature).
- perf_stall_cnt  output  32  pc_hold cycles.
- perf_flush_cnt  output  32  flushes.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC.
  - ifid_instr = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0.
  - All perf counters = 0.
  - imem_req = 0 while reset is high.
- pc4 = pc + 32'd4, modulo 2^32; the wrap from 32'hFFFF_FFFC to 0 is legal and unchecked.
- Next-PC priority, evaluated at each rising clk edge:
  1. pc_hold=1: pc unchanged.
  2. branch_taken=1: pc = {branch_target[31:2],2'b00}.
  3. jump_taken=1: pc = {pc4[31:28], jump_index, 2'b00}, where pc4 is the IF/ID copy (ifid_pc4).
  4. imem_ready=0: pc unchanged (fetch retried).
  5. Otherwise: pc = pc4.
- branch_taken wins over jump_taken if both are asserted.
- The ID stage gates branch_taken and jump_taken with the stall; a redirect during pc_hold is a protocol violation, covered by an assertion.
- IF/ID update priority, at each rising clk edge:
  1. ifid_hold=1: all IF/ID fields retain their values. if_flush is ignored here; the bubble is inserted by the ID control mux, because the hazard unit raises all three signals together on a stall.
  2. if_flush=1, branch_taken=1 or jump_taken=1: ifid_instr = NOP_INSTR, ifid_valid = 0, ifid_pc4 = pc4.
  3. imem_ready=0: bubble (NOP_INSTR, valid = 0, ifid_pc4 = pc4).
  4. Otherwise: ifid_instr = imem_rdata, ifid_pc4 = pc4, ifid_valid = 1.
- Latency: instruction at PC P appears on ifid_instr one cycle after the edge where imem_ready=1 with imem_addr=P.
- Taken branch penalty: exactly one squashed slot.
- Mixed holds: pc_hold=1 with ifid_hold=0 is legal; IF/ID follows rules 2–4 and may capture the same PC again.
- Mixed holds: ifid_hold=1 with pc_hold=0 is legal; the PC advances and the fetched word is dropped.
- Reset asserted mid-stall or during a memory wait: state returns to reset values at once. The first fetch after reset deassertion is at RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, cleared by reset.
  - perf_fetch_cnt increments on each IF/ID load with valid = 1.
  - perf_stall_cnt increments on each cycle with pc_hold = 1.
  - perf_flush_cnt increments on each IF/ID load taking rule 2.
- Undefined: counter logic is absent and the three ports are tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (R_FORMAT, LW, SW, BEQ, J);
  - NOP_INSTR value;
  - RESET_PC default;
  - a word-align helper function.
- One sub-module, if_id_reg: IF/ID register with hold/flush/bubble priority. fetch_stage contains the PC logic and optional counters.

Test Plan:
- Reset, then imem_ready=1 for 3 cycles with rdata 0x8C010000, 0x00221820, 0x10000002 → pc steps 0, 4, 8, 0xC. IF/ID shows each word with ifid_pc4 4, 8, 0xC and valid=1.
- pc_hold=ifid_hold=if_flush=1 for 2 cycles at pc=8 → pc stays 8, IF/ID unchanged; after release, the next load captures the word at 8. perf_stall_cnt=2 if enabled.
- branch_taken=1, branch_target=0x40 at pc=0x10 → next pc=0x40, ifid_instr=NOP_INSTR with valid=0, then the word at 0x40 arrives.
- jump_taken=1, jump_index=26'h0000100, ifid_pc4=0x0040_0010 → next pc=0x0000_0400.
- imem_ready=0 for 3 cycles at pc=0x20 → pc holds at 0x20, three bubbles with valid=0. When ready rises, the word is captured with ifid_pc4=0x24.
- Assert reset for 1 cycle mid-wait at pc=0x30 → pc=0 and valid=0 immediately (asynchronously); the first fetch after deassertion is at address 0.
